// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes and
// the select codes understood by the ALU decoder and the datapath muxes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic op_is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core.
//
// state   | meaning
// FETCH   | read instruction at PC, PC+4; waits on mem_ready
// DECODE  | register read, branch target precompute, dispatch on op
// MEMADR  | effective address for lw/sw
// MEMRD   | data read; waits on mem_ready
// MEMWB   | load result written to rt
// MEMWR   | data write; strobe held until mem_ready
// EXECUTE | R-type ALU operation
// ALUWB   | R-type result written to rd
// BRANCH  | beq compare, PC updated when zero
// ADDIEX  | addi ALU operation
// ADDIWB  | addi result written to rt
// JUMP    | PC loaded with jump target
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       IorD,
   output logic       mem_write,
   output logic       IR_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       ALU_src_A,
   output logic [1:0] ALU_src_B,
   output logic [1:0] ALU_OP,
   output logic [1:0] PC_src,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_e state_q, state_d;
   logic   pc_en_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

   // State register; reset drops straight back to FETCH mid-instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state sequencing; mem_ready matters only in the memory-access states.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   // Output decode; FETCH strobes follow mem_ready, BRANCH pc_en follows zero.
   always_comb begin
      pc_en_raw     = 1'b0;
      IorD          = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write_raw = 1'b0;
      ALU_src_A     = 1'b0;
      ALU_src_B     = SRCB_REG;
      ALU_OP        = ALUOP_ADD;
      PC_src        = PCSRC_ALU;
      illegal_raw   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALU_src_B    = SRCB_FOUR;
            ir_write_raw = mem_ready;
            pc_en_raw    = mem_ready;
         end
         S_DECODE: begin
            ALU_src_B   = SRCB_IMM_SH2;
            illegal_raw = !op_is_legal(op);
         end
         S_MEMADR: begin
            ALU_src_A = 1'b1;
            ALU_src_B = SRCB_IMM;
         end
         S_MEMRD:  IorD = 1'b1;
         S_MEMWB: begin
            mem_to_reg    = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_MEMWR: begin
            IorD          = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECUTE: begin
            ALU_src_A = 1'b1;
            ALU_OP    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_dst       = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_BRANCH: begin
            ALU_src_A = 1'b1;
            ALU_OP    = ALUOP_SUB;
            PC_src    = PCSRC_ALUOUT;
            pc_en_raw = zero;
         end
         S_ADDIEX: begin
            ALU_src_A = 1'b1;
            ALU_src_B = SRCB_IMM;
         end
         S_ADDIWB: reg_write_raw = 1'b1;
         S_JUMP: begin
            PC_src    = PCSRC_JUMP;
            pc_en_raw = 1'b1;
         end
         default:  illegal_raw = 1'b1;
      endcase
   end

   // Strobes are masked while reset is held so nothing writes during abort.
   assign pc_en      = pc_en_raw & rst_n;
   assign mem_write  = mem_write_raw & rst_n;
   assign IR_write   = ir_write_raw & rst_n;
   assign reg_write  = reg_write_raw & rst_n;
   assign illegal_op = illegal_raw & rst_n;
   assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for the multicycle MIPS control FSM: directed cases plus a random
// instruction stream, each cycle compared against a per-phase reference table.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op_r;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, IorD, mem_write, IR_write, reg_dst, mem_to_reg, reg_write;
   logic       ALU_src_A, illegal_op;
   logic [1:0] ALU_src_B, ALU_OP, PC_src;
   logic [3:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [5:0] LEGAL_OPS [6] = '{6'b000000, 6'b100011, 6'b101011,
                                            6'b000100, 6'b001000, 6'b000010};

   mips_multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op_r), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .IorD(IorD), .mem_write(mem_write), .IR_write(IR_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .ALU_OP(ALU_OP),
      .PC_src(PC_src), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   wire [14:0] obs_vec = {pc_en, IorD, mem_write, IR_write, reg_dst, mem_to_reg,
                          reg_write, ALU_src_A, ALU_src_B, ALU_OP, PC_src, illegal_op};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic bit is_legal(input logic [5:0] o);
      foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == o) return 1'b1;
      return 1'b0;
   endfunction

   // Reference: expected output word for a phase numbered as in the state list.
   function automatic logic [14:0] exp_vec(input int st, input bit mr, input bit z,
                                           input logic [5:0] o);
      bit pe = 0, iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
      logic [1:0] sb = 2'b00, aop = 2'b00, pcs = 2'b00;
      case (st)
         0:  begin sb = 2'b01; irw = mr; pe = mr; end
         1:  begin sb = 2'b11; ill = !is_legal(o); end
         2:  begin sa = 1; sb = 2'b10; end
         3:  iord = 1;
         4:  begin m2r = 1; rw = 1; end
         5:  begin iord = 1; mw = 1; end
         6:  begin sa = 1; aop = 2'b10; end
         7:  begin rd = 1; rw = 1; end
         8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pe = z; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin pcs = 2'b10; pe = 1; end
         default: ill = 1;
      endcase
      return {pe, iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, ill};
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One cycle: drive inputs, compare state and outputs mid-cycle, advance.
   task automatic step(input int st, input bit mr, input bit z);
      mem_ready = mr;
      zero      = z;
      @(negedge clk);
      check($sformatf("state_op%0h", op_r), 32'(state), 32'(st));
      check($sformatf("outs_st%0d", st), 32'(obs_vec), 32'(exp_vec(st, mr, z, op_r)));
      @(posedge clk);
      #1;
   endtask

   // Walks one instruction: fw fetch waits, mw data waits, z used in BRANCH.
   task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input bit z);
      int ms;
      op_r = o;
      for (int i = 0; i < fw; i++) step(0, 1'b0, rb());
      step(0, 1'b1, rb());
      step(1, rb(), rb());
      case (o)
         6'b100011, 6'b101011: begin
            step(2, rb(), rb());
            ms = (o == 6'b100011) ? 3 : 5;
            for (int i = 0; i < mw; i++) step(ms, 1'b0, rb());
            step(ms, 1'b1, rb());
            if (o == 6'b100011) step(4, rb(), rb());
         end
         6'b000000: begin step(6, rb(), rb()); step(7, rb(), rb()); end
         6'b000100: step(8, rb(), z);
         6'b001000: begin step(9, rb(), rb()); step(10, rb(), rb()); end
         6'b000010: step(11, rb(), rb());
         default: ;
      endcase
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_outs"}, 32'(obs_vec), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                              1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0}));
   endtask

   initial begin
      rst_n = 1'b0;
      mem_ready = 1'b1;
      zero = 1'b1;
      op_r = 6'b000000;
      #2;
      check_reset_outputs("por");
      @(posedge clk); #1;
      check_reset_outputs("por_hold");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed cases from the test plan.
      run_instr(6'b000000, 0, 0, 0);          // R-type, zero-wait
      run_instr(6'b100011, 0, 2, 0);          // lw, 2 waits in MEMRD
      run_instr(6'b000100, 0, 0, 1);          // beq taken
      run_instr(6'b000100, 0, 0, 0);          // beq not taken
      run_instr(6'b101011, 1, 1, 0);          // sw, fetch wait and write wait
      run_instr(6'b111111, 0, 0, 0);          // illegal opcode
      run_instr(6'b001000, 0, 0, 0);          // addi
      run_instr(6'b000010, 2, 0, 0);          // j after fetch waits

      // Reset asserted mid-EXECUTE for two cycles.
      op_r = 6'b000000;
      step(0, 1'b1, 1'b0);
      step(1, 1'b1, 1'b0);
      mem_ready = 1'b1;
      @(negedge clk);
      check("abort_pre_state", 32'(state), 32'd6);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(posedge clk); #1;
      check_reset_outputs("abort_c1");
      @(posedge clk); #1;
      check_reset_outputs("abort_c2");
      rst_n = 1'b1;
      run_instr(6'b000000, 0, 0, 0);

      // Random instruction stream.
      for (int n = 0; n < 60; n++) begin
         logic [5:0] o;
         if ($urandom_range(0, 7) == 0) o = 6'($urandom);
         else o = LEGAL_OPS[$urandom_range(0, 5)];
         run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3), rb());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
